stage_mem: RTL and testbench

MIPS memory stage, directly downstream of stage_exe. Registers the EX/MEM boundary and performs byte/half/word loads and stores to an internal synchronous data memory. Forwards the branch decision (use_npc, jump_address) to fetch. Drives the MEM/WB values consumed by write-back. After every reset, an init state machine zeroes the data memory before the stage accepts work.

---
 rtl/stage_mem.sv | 207 ++++++++++++++++++++
 tb/tb_stage_mem.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/stage_mem.sv
// stage_mem: MIPS memory stage.
// Registers the EX/MEM boundary. Performs byte, half and word loads and stores
// on an internal synchronous data memory. Forwards the branch decision to fetch.
// After every reset, an init sequence zeroes the memory before the stage accepts work.
//
// Ports:
//   clock, reset               rising-edge clock; synchronous reset, active low
//   stall                      hold every output register and block stores
//   alu_out, data_b            byte address / ALU result, and store data
//   control_mem_*              read, write, size (00 b, 01 h, 1x w), unsigned
//   control_reg_write          write-back enable
//   reg_dest                   write-back destination register
//   use_npc, jump_address      branch decision and branch target from execute
//   ready                      low while the memory is being zeroed
//   mem_data                   extended load result (0 when there is no load)
//   alu_result                 registered alu_out
//   out_reg_write              registered write-back enable
//   out_reg_dest               registered destination register
//   pc_src                     registered branch-taken flag
//   branch_target              registered jump_address
//   misaligned                 flag for an illegal-alignment access
// Lane handling assumes DATA_WIDTH = 32 (four byte lanes).
module stage_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic                  control_mem_read,
    input  logic                  control_mem_write,
    input  logic [1:0]            control_mem_size,
    input  logic                  control_mem_unsigned,
    input  logic                  control_reg_write,
    input  logic [4:0]            reg_dest,
    input  logic                  use_npc,
    input  logic [DATA_WIDTH-1:0] jump_address,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] alu_result,
    output logic                  out_reg_write,
    output logic [4:0]            out_reg_dest,
    output logic                  pc_src,
    output logic [DATA_WIDTH-1:0] branch_target,
    output logic                  misaligned
);
    localparam int MEM_DEPTH = 2 ** ADDR_BITS;

    typedef enum logic {S_INIT, S_RUN} state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    state_t                state_q, state_d;
    logic [ADDR_BITS-1:0]  cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] alu_q, alu_d;
    logic                  regw_q, regw_d;
    logic [4:0]            dest_q, dest_d;
    logic                  pcsrc_q, pcsrc_d;
    logic [DATA_WIDTH-1:0] tgt_q, tgt_d;
    logic                  mis_q, mis_d;

    // Upper address bits are ignored, so the memory wraps modulo its size.
    logic [ADDR_BITS-1:0]  idx;
    logic [1:0]            lane;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  is_byte, is_half, is_word, mis;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [DATA_WIDTH-1:0] load_val;
    logic                  we;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  unused_hi;

    assign idx       = alu_out[ADDR_BITS+1:2];
    assign lane      = alu_out[1:0];
    assign unused_hi = ^alu_out[DATA_WIDTH-1:ADDR_BITS+2];
    assign rd_word   = mem[idx];
    assign is_byte   = (control_mem_size == 2'b00);
    assign is_half   = (control_mem_size == 2'b01);
    assign is_word   = control_mem_size[1];   // 11 is treated as word
    assign mis       = (control_mem_read | control_mem_write) &
                       ((is_half & lane[0]) | (is_word & (lane != 2'b00)));

    // Load extraction. Memory is read before this edge's store, so a
    // simultaneous read and write returns the pre-store value.
    always_comb begin
        rd_byte  = rd_word[7:0];
        case (lane)
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            2'd3:    rd_byte = rd_word[31:24];
            default: rd_byte = rd_word[7:0];
        endcase
        rd_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];
        load_val = rd_word;
        if (is_byte)
            load_val = {{24{rd_byte[7] & ~control_mem_unsigned}}, rd_byte};
        else if (is_half)
            load_val = {{16{rd_half[15] & ~control_mem_unsigned}}, rd_half};
    end

    // Store lane enables; data is replicated so each lane sees its slice.
    always_comb begin
        we    = (state_q == S_RUN) & ~stall & control_mem_write & ~mis;
        be    = 4'b1111;
        wdata = data_b;
        if (is_byte) begin
            be    = 4'b0001 << lane;
            wdata = {4{data_b[7:0]}};
        end else if (is_half) begin
            be    = lane[1] ? 4'b1100 : 4'b0011;
            wdata = {2{data_b[15:0]}};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        data_d  = data_q;
        alu_d   = alu_q;
        regw_d  = regw_q;
        dest_d  = dest_q;
        pcsrc_d = pcsrc_q;
        tgt_d   = tgt_q;
        mis_d   = mis_q;
        case (state_q)
            S_INIT: begin
                cnt_d   = cnt_q + 1'b1;
                data_d  = '0;
                alu_d   = '0;
                regw_d  = 1'b0;
                dest_d  = '0;
                pcsrc_d = 1'b0;
                tgt_d   = '0;
                mis_d   = 1'b0;
                if (cnt_q == ADDR_BITS'(MEM_DEPTH - 1)) begin
                    state_d = S_RUN;
                    ready_d = 1'b1;
                end
            end
            default: begin
                if (!stall) begin
                    data_d  = (control_mem_read && !mis) ? load_val : '0;
                    alu_d   = alu_out;
                    regw_d  = control_reg_write & ~mis;
                    dest_d  = reg_dest;
                    pcsrc_d = ~use_npc;
                    tgt_d   = jump_address;
                    mis_d   = mis;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            data_q  <= '0;
            alu_q   <= '0;
            regw_q  <= 1'b0;
            dest_q  <= '0;
            pcsrc_q <= 1'b0;
            tgt_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            data_q  <= data_d;
            alu_q   <= alu_d;
            regw_q  <= regw_d;
            dest_q  <= dest_d;
            pcsrc_q <= pcsrc_d;
            tgt_q   <= tgt_d;
            mis_q   <= mis_d;
        end
    end

    // Memory array has no reset; the init sequence clears it word by word.
    always_ff @(posedge clock) begin
        if (reset) begin
            if (state_q == S_INIT) begin
                mem[cnt_q] <= '0;
            end else if (we) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    assign ready         = ready_q;
    assign mem_data      = data_q;
    assign alu_result    = alu_q;
    assign out_reg_write = regw_q;
    assign out_reg_dest  = dest_q;
    assign pc_src        = pcsrc_q;
    assign branch_target = tgt_q;
    assign misaligned    = mis_q;
endmodule

// File: tb/tb_stage_mem.sv
module tb_stage_mem;
    logic        clock = 1'b0;
    logic        reset, stall;
    logic [31:0] alu_out, data_b, jump_address;
    logic        control_mem_read, control_mem_write, control_mem_unsigned;
    logic [1:0]  control_mem_size;
    logic        control_reg_write, use_npc;
    logic [4:0]  reg_dest;
    logic        ready, out_reg_write, pc_src, misaligned;
    logic [31:0] mem_data, alu_result, branch_target;
    logic [4:0]  out_reg_dest;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    stage_mem #(.DATA_WIDTH(32), .ADDR_BITS(8)) dut (
        .clock(clock), .reset(reset), .stall(stall),
        .alu_out(alu_out), .data_b(data_b),
        .control_mem_read(control_mem_read), .control_mem_write(control_mem_write),
        .control_mem_size(control_mem_size), .control_mem_unsigned(control_mem_unsigned),
        .control_reg_write(control_reg_write), .reg_dest(reg_dest),
        .use_npc(use_npc), .jump_address(jump_address),
        .ready(ready), .mem_data(mem_data), .alu_result(alu_result),
        .out_reg_write(out_reg_write), .out_reg_dest(out_reg_dest),
        .pc_src(pc_src), .branch_target(branch_target), .misaligned(misaligned)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in();
        stall = 0; alu_out = 0; data_b = 0; jump_address = 0;
        control_mem_read = 0; control_mem_write = 0; control_mem_size = 2'b10;
        control_mem_unsigned = 0; control_reg_write = 0; reg_dest = 0; use_npc = 1;
    endtask

    // One memory operation; outputs are sampled just after the edge.
    task automatic op(input logic rd, input logic wr, input logic [1:0] sz,
                      input logic uns, input logic [31:0] addr, input logic [31:0] d);
        idle_in();
        control_mem_read = rd; control_mem_write = wr; control_mem_size = sz;
        control_mem_unsigned = uns; alu_out = addr; data_b = d;
        tick();
    endtask

    // Hold reset for n edges, release, and check the 256-cycle init window.
    task automatic do_reset(input int n, input string tag);
        int  cyc;
        logic nz;
        idle_in();
        reset = 0;
        repeat (n) tick();
        chk({tag, "_rst_ready"}, {31'b0, ready}, 32'd0);
        nz = |{mem_data, alu_result, branch_target, out_reg_dest,
               out_reg_write, pc_src, misaligned};
        chk({tag, "_rst_outs"}, {31'b0, nz}, 32'd0);
        reset = 1;
        cyc = 0;
        nz = 0;
        do begin
            tick();
            cyc++;
            nz |= |{mem_data, alu_result, branch_target, out_reg_dest,
                    out_reg_write, pc_src, misaligned};
        end while (!ready && cyc < 1000);
        chk({tag, "_init_cycles"}, cyc, 32'd256);
        chk({tag, "_init_outs"}, {31'b0, nz}, 32'd0);
    endtask

    initial begin
        idle_in();
        reset = 0;
        do_reset(3, "r1");

        op(1, 0, 2'b10, 0, 32'h10, 0);
        chk("ld_zero_0x10", mem_data, 32'h0);

        op(0, 1, 2'b10, 0, 32'h20, 32'h8000_00F1);
        op(1, 0, 2'b00, 0, 32'h20, 0);  chk("lb_s",  mem_data, 32'hFFFF_FFF1);
        op(1, 0, 2'b00, 1, 32'h20, 0);  chk("lb_u",  mem_data, 32'h0000_00F1);
        op(1, 0, 2'b01, 0, 32'h22, 0);  chk("lh_s",  mem_data, 32'hFFFF_8000);
        op(1, 0, 2'b01, 1, 32'h22, 0);  chk("lh_u",  mem_data, 32'h0000_8000);
        op(1, 0, 2'b01, 0, 32'h20, 0);  chk("lh_lo", mem_data, 32'h0000_00F1);
        op(1, 0, 2'b10, 0, 32'h20, 0);  chk("lw",    mem_data, 32'h8000_00F1);
        op(1, 0, 2'b00, 0, 32'h23, 0);  chk("lb_s3", mem_data, 32'hFFFF_FF80);

        op(0, 1, 2'b10, 0, 32'h40, 32'h1122_3344);
        op(0, 1, 2'b00, 0, 32'h41, 32'hFFFF_FFAB);
        op(1, 0, 2'b10, 0, 32'h40, 0);  chk("sb_merge", mem_data, 32'h1122_AB44);
        op(0, 1, 2'b00, 0, 32'h441, 32'hCD);
        op(1, 0, 2'b10, 0, 32'h40, 0);  chk("sb_wrap",  mem_data, 32'h1122_CD44);

        // Misaligned half store with write-back requested.
        idle_in();
        control_mem_write = 1; control_mem_size = 2'b01; alu_out = 32'h43;
        data_b = 32'h9999; control_reg_write = 1; reg_dest = 5'd3;
        tick();
        chk("mis_flag", {31'b0, misaligned}, 32'd1);
        chk("mis_regw", {31'b0, out_reg_write}, 32'd0);
        chk("mis_alu",  alu_result, 32'h43);
        op(1, 0, 2'b10, 0, 32'h40, 0);
        chk("mis_clear", {31'b0, misaligned}, 32'd0);
        chk("mis_nostore", mem_data, 32'h1122_CD44);
        op(1, 0, 2'b10, 0, 32'h21, 0);
        chk("mis_lw_flag", {31'b0, misaligned}, 32'd1);
        chk("mis_lw_data", mem_data, 32'h0);

        // Read+write together: old data returned, new data stored.
        op(1, 1, 2'b10, 0, 32'h40, 32'hDEAD_BEEF);
        chk("rw_old", mem_data, 32'h1122_CD44);
        op(1, 0, 2'b10, 0, 32'h40, 0);  chk("rw_new", mem_data, 32'hDEAD_BEEF);

        idle_in();
        control_reg_write = 1; reg_dest = 5'd7; alu_out = 32'h99;
        tick();
        chk("wb_en",   {31'b0, out_reg_write}, 32'd1);
        chk("wb_dest", {27'b0, out_reg_dest}, 32'd7);
        chk("wb_alu",  alu_result, 32'h99);
        chk("wb_nold", mem_data, 32'h0);

        // Branch, then two stalled cycles carrying a store.
        idle_in();
        use_npc = 0; jump_address = 32'd12; alu_out = 32'h30;
        tick();
        chk("br_pcsrc", {31'b0, pc_src}, 32'd1);
        chk("br_tgt",   branch_target, 32'd12);
        idle_in();
        stall = 1; control_mem_write = 1; alu_out = 32'h30; data_b = 32'h77;
        tick();
        tick();
        chk("stall_pcsrc", {31'b0, pc_src}, 32'd1);
        chk("stall_tgt",   branch_target, 32'd12);
        chk("stall_alu",   alu_result, 32'h30);
        op(1, 0, 2'b10, 0, 32'h30, 0);
        chk("stall_nostore", mem_data, 32'h0);
        chk("unstall_pcsrc", {31'b0, pc_src}, 32'd0);

        // Reset in RUN re-zeroes memory.
        op(0, 1, 2'b00, 0, 32'h8, 32'h55);
        op(1, 0, 2'b10, 0, 32'h8, 0);  chk("pre_rst", mem_data, 32'h55);
        do_reset(2, "r2");
        op(1, 0, 2'b10, 0, 32'h8, 0);  chk("post_rst", mem_data, 32'h0);
        op(1, 0, 2'b10, 0, 32'h40, 0); chk("post_rst40", mem_data, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
